// File: rtl/spi_flash_master.sv
// SPI mode-0 master for the configuration flash: byte shift engine, software chip select, status flags.
// Sits on the registered I/O bus; rd is combinational and zero when no select is active.
//
// state | meaning
// IDLE  | no byte in flight, sck low, CS changes apply immediately
// SHIFT | byte in flight, sck toggles every DIV clk, CS changes held pending
module spi_flash_master #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic        sel_data,
  input  logic        sel_ctrl,
  input  logic [15:0] wd,
  output logic [15:0] rd,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n,
  output logic        busy
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] divcnt;
  logic [2:0]    bitcnt;
  logic [7:0]    tx_sr, rx_sr, rx_data;
  logic          rx_valid, overrun, cs_pend, cs_pend_vld;
  logic          data_wr, ctrl_wr, data_rd, start, tick, done, cs_defer;
  logic          unused_wd;

  assign data_wr   = io_wr & sel_data;
  assign ctrl_wr   = io_wr & sel_ctrl;
  assign data_rd   = io_rd & sel_data;
  assign start     = data_wr & (state == IDLE);
  assign tick      = (divcnt == DW'(DIV - 1));
  assign done      = (state == SHIFT) & tick & sck & (bitcnt == 3'd7);
  assign cs_defer  = ((state == SHIFT) & ~done) | start;
  assign mosi      = tx_sr[7];
  assign unused_wd = ^wd[15:8];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    rd   = 16'd0;
    if (sel_data) rd = rd | {8'd0, rx_data};
    if (sel_ctrl) rd = rd | {12'd0, ~cs_n, overrun, rx_valid, (state == SHIFT)};
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sck         <= 1'b0;
      divcnt      <= '0;
      bitcnt      <= 3'd0;
      tx_sr       <= 8'd0;
      rx_sr       <= 8'd0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      cs_n        <= 1'b1;
      cs_pend     <= 1'b1;
      cs_pend_vld <= 1'b0;
    end else begin
      if (start) begin
        tx_sr  <= wd[7:0];
        bitcnt <= 3'd0;
        divcnt <= '0;
        sck    <= 1'b0;
      end else if (state == SHIFT) begin
        if (tick) begin
          divcnt <= '0;
          sck    <= ~sck;
          if (!sck) begin
            rx_sr <= {rx_sr[6:0], miso};
          end else if (bitcnt != 3'd7) begin
            tx_sr  <= tx_sr << 1;
            bitcnt <= bitcnt + 3'd1;
          end else begin
            rx_data <= rx_sr;
            bitcnt  <= 3'd0;
          end
        end else begin
          divcnt <= divcnt + 1'b1;
        end
      end

      // completion beats a coincident read clear
      if (done)         rx_valid <= 1'b1;
      else if (data_rd) rx_valid <= 1'b0;

      if (data_wr & (state == SHIFT)) overrun <= 1'b1;
      else if (ctrl_wr & wd[1])       overrun <= 1'b0;

      // CS requests made while a byte is in flight land on its completion edge
      if (ctrl_wr & cs_defer) begin
        cs_pend     <= ~wd[0];
        cs_pend_vld <= 1'b1;
      end else if (ctrl_wr) begin
        cs_n        <= ~wd[0];
        cs_pend_vld <= 1'b0;
      end else if (done & cs_pend_vld) begin
        cs_n        <= cs_pend;
        cs_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_master.sv
// Bench for spi_flash_master: DIV=2 instance for the main scenarios, DIV=1 instance for the short-byte race.
// Transmitted and received bytes are predicted into queues and popped when the DUT shifts or returns them.
module tb_spi_flash_master;

  logic        clk, resetq, io_wr, io_rd, sel_data, sel_ctrl, miso, loop;
  logic [15:0] wd;
  logic [7:0]  pat;
  logic [15:0] rd0, rd1;
  logic        sck0, mosi0, cs_n0, busy0;
  logic        sck1, mosi1, cs_n1, busy1;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rise = 0;
  int          nb;
  logic [7:0]  sh;
  logic [2:0]  fcnt;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  spi_flash_master #(.DIV(2)) u_dut (
    .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd),
    .sel_data(sel_data), .sel_ctrl(sel_ctrl), .wd(wd), .rd(rd0),
    .sck(sck0), .mosi(mosi0), .miso(miso), .cs_n(cs_n0), .busy(busy0)
  );

  spi_flash_master #(.DIV(1)) u_dut1 (
    .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd),
    .sel_data(sel_data), .sel_ctrl(sel_ctrl), .wd(wd), .rd(rd1),
    .sck(sck1), .mosi(mosi1), .miso(miso), .cs_n(cs_n1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign miso = loop ? mosi0 : pat[3'd7 - fcnt];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // flash-side view of MOSI: one byte per 8 rising sck edges
  always @(posedge sck0 or negedge resetq) begin
    if (!resetq) begin
      nb = 0;
      sh = 8'd0;
    end else begin
      sh = {sh[6:0], mosi0};
      nb++;
      n_rise++;
      if (nb == 8) begin
        nb = 0;
        if (tx_q.size() == 0) check("tx_unexpected", {8'd0, sh}, 16'hffff);
        else                  check("mosi_byte", {8'd0, sh}, {8'd0, tx_q.pop_front()});
      end
    end
  end

  always @(negedge sck0 or negedge resetq) begin
    if (!resetq) fcnt = 3'd0;
    else         fcnt = fcnt + 3'd1;
  end

  task automatic data_wr(input logic [7:0] b, input logic accept, input logic [7:0] rx_exp);
    if (accept) begin
      tx_q.push_back(b);
      rx_q.push_back(rx_exp);
    end
    io_wr = 1'b1; sel_data = 1'b1; wd = {8'hEE, b};
    @(negedge clk);
    io_wr = 1'b0; sel_data = 1'b0; wd = 16'd0;
  endtask

  task automatic ctrl_wr(input logic [15:0] v);
    io_wr = 1'b1; sel_ctrl = 1'b1; wd = v;
    @(negedge clk);
    io_wr = 1'b0; sel_ctrl = 1'b0; wd = 16'd0;
  endtask

  task automatic bus_rd(input logic d, input logic c, output logic [15:0] v0, output logic [15:0] v1);
    io_rd = 1'b1; sel_data = d; sel_ctrl = c;
    #1;
    v0 = rd0;
    v1 = rd1;
    @(negedge clk);
    io_rd = 1'b0; sel_data = 1'b0; sel_ctrl = 1'b0;
  endtask

  task automatic check_rx(input string tag, input logic [15:0] got, input logic [15:0] or_mask);
    if (rx_q.size() == 0) check({tag, "_q_empty"}, 16'd1, 16'd0);
    else                  check(tag, got, {8'd0, rx_q.pop_front()} | or_mask);
  endtask

  task automatic wait_idle0();
    int k;
    k = 0;
    while (busy0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy0) check("idle_timeout", 16'd1, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v0, v1;
    int cnt, bad, r0;

    resetq = 1'b0; io_wr = 1'b0; io_rd = 1'b0; sel_data = 1'b0; sel_ctrl = 1'b0;
    wd = 16'd0; loop = 1'b1; pat = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_sck", {15'd0, sck0}, 16'd0);
    check("rst_cs_n", {15'd0, cs_n0}, 16'd1);
    check("rst_busy", {15'd0, busy0}, 16'd0);
    check("rst_mosi", {15'd0, mosi0}, 16'd0);
    resetq = 1'b1;
    @(negedge clk);
    bus_rd(1'b0, 1'b1, v0, v1);
    check("rst_status", v0, 16'h0000);

    // loopback A5
    ctrl_wr(16'h0001);
    check("cs_assert", {15'd0, cs_n0}, 16'd0);
    r0 = n_rise;
    data_wr(8'hA5, 1'b1, 8'hA5);
    cnt = 0; bad = 0;
    while (busy0 && cnt < 200) begin
      if (cs_n0) bad++;
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 16'(cnt), 16'd32);
    check("cs_during", 16'(bad), 16'd0);
    check("sck_rises", 16'(n_rise - r0), 16'd8);
    bus_rd(1'b0, 1'b1, v0, v1);
    check("status_done", v0, 16'h000A);
    bus_rd(1'b1, 1'b0, v0, v1);
    check_rx("rx_loop", v0, 16'h0000);
    bus_rd(1'b0, 1'b1, v0, v1);
    check("status_read", v0, 16'h0008);

    // flash drives 0x3C on MISO while 0xFF goes out
    loop = 1'b0; pat = 8'h3C;
    data_wr(8'hFF, 1'b1, 8'h3C);
    wait_idle0();
    bus_rd(1'b1, 1'b1, v0, v1);
    check_rx("rx_miso_both_sel", v0, 16'h000A);
    loop = 1'b1;

    // overrun: second write at cycle 5 is dropped
    data_wr(8'h12, 1'b1, 8'h12);
    repeat (4) @(negedge clk);
    data_wr(8'h34, 1'b0, 8'h00);
    wait_idle0();
    bus_rd(1'b0, 1'b1, v0, v1);
    check("status_overrun", v0, 16'h000E);
    bus_rd(1'b1, 1'b0, v0, v1);
    check_rx("rx_overrun", v0, 16'h0000);
    ctrl_wr(16'h0003);
    bus_rd(1'b0, 1'b1, v0, v1);
    check("status_ov_clr", v0, 16'h0008);
    check("cs_kept", {15'd0, cs_n0}, 16'd0);

    // deferred CS release at cycle 10
    data_wr(8'h5A, 1'b1, 8'h5A);
    repeat (9) @(negedge clk);
    ctrl_wr(16'h0000);
    cnt = 0; bad = 0;
    while (busy0 && cnt < 200) begin
      if (cs_n0) bad++;
      cnt++;
      @(negedge clk);
    end
    check("cs_held", 16'(bad), 16'd0);
    check("cs_release", {15'd0, cs_n0}, 16'd1);
    bus_rd(1'b1, 1'b0, v0, v1);
    check_rx("rx_defer", v0, 16'h0000);
    bus_rd(1'b0, 1'b1, v0, v1);
    check("status_idle", v0, 16'h0000);

    // async reset mid-transfer
    ctrl_wr(16'h0001);
    data_wr(8'h77, 1'b0, 8'h00);
    repeat (6) @(negedge clk);
    #2 resetq = 1'b0;
    #1;
    check("abort_busy", {15'd0, busy0}, 16'd0);
    check("abort_cs_n", {15'd0, cs_n0}, 16'd1);
    check("abort_sck", {15'd0, sck0}, 16'd0);
    check("abort_busy1", {15'd0, busy1}, 16'd0);
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);

    // DIV=1: 16-cycle byte and read clear on the completion edge
    data_wr(8'hC3, 1'b1, 8'hC3);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy1) cnt++;
      if (i == 15) begin
        io_rd = 1'b1; sel_data = 1'b1;
      end
      @(negedge clk);
    end
    io_rd = 1'b0; sel_data = 1'b0;
    check("div1_busy_cycles", 16'(cnt), 16'd16);
    check("div1_idle", {15'd0, busy1}, 16'd0);
    bus_rd(1'b0, 1'b1, v0, v1);
    check("div1_race_status", v1, 16'h0002);
    bus_rd(1'b1, 1'b0, v0, v1);
    bus_rd(1'b0, 1'b1, v0, v1);
    check("div1_rx_cleared", v1, 16'h0000);
    wait_idle0();
    bus_rd(1'b1, 1'b0, v0, v1);
    check_rx("rx_c3", v0, 16'h0000);

    check("tx_q_left", 16'(tx_q.size()), 16'd0);
    check("rx_q_left", 16'(rx_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
